// File: rtl/lcd_queue_reader.sv
// -----------------------------------------------------------------------------
// lcd_queue_reader
//   Pulls a tagged pixel stream out of a show-ahead FIFO and plays it onto an
//   RGB565 LCD with free-running sync/porch timing. Stream words:
//     0x10000 frame start, 0x10001 row start, 0x1FFFF frame end,
//     bit16 = 0 pixel (RGB565 in bits 15:0).
//   The FSM aligns the stream to the raster and falls back to RESYNC on any
//   framing error or starvation; the raster itself never stalls.
//
// Ports
//   clk, reset_n     pixel clock, asynchronous active-low reset
//   queue_data[16:0] FIFO head word (valid while queue_empty = 0)
//   queue_empty      FIFO empty
//   queue_rd_en      pop request (word consumed on clk rise with !queue_empty)
//   lcd_de           data enable
//   lcd_hsync/vsync  active-low syncs
//   lcd_r/g/b        RGB565 pixel
//   locked           stream aligned to raster
//   underflow        sticky error flag, cleared only by reset
//   o_dbg_state      current FSM state
//
// Handshake: queue_rd_en is a combinational request; a word is taken on every
//   rising clk where queue_rd_en = 1 and queue_empty = 0, and never otherwise.
//
// Build option: LCD_READER_BLUE_SCREEN_EN makes the idle colour blue (0x001F)
//   while unlocked; without it the idle colour is always black.
// -----------------------------------------------------------------------------
module lcd_queue_reader #(
  parameter int FRAME_WIDTH  = 480,
  parameter int FRAME_HEIGHT = 272,
  parameter int H_SYNC       = 4,
  parameter int H_BP         = 43,
  parameter int H_FP         = 8,
  parameter int V_SYNC       = 4,
  parameter int V_BP         = 12,
  parameter int V_FP         = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [16:0] queue_data,
  input  logic        queue_empty,
  output logic        queue_rd_en,
  output logic        lcd_de,
  output logic        lcd_hsync,
  output logic        lcd_vsync,
  output logic [4:0]  lcd_r,
  output logic [5:0]  lcd_g,
  output logic [4:0]  lcd_b,
  output logic        locked,
  output logic        underflow,
  output logic [2:0]  o_dbg_state
);

  localparam int H_TOTAL = H_SYNC + H_BP + FRAME_WIDTH + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + FRAME_HEIGHT + V_FP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_SYNC_END = HW'(H_SYNC);
  localparam logic [HW-1:0] H_ACT_BEG  = HW'(H_SYNC + H_BP);
  localparam logic [HW-1:0] H_ACT_END  = HW'(H_SYNC + H_BP + FRAME_WIDTH);
  localparam logic [HW-1:0] H_PRE      = HW'(H_SYNC + H_BP - 1);
  localparam logic [HW-1:0] H_ACT_LAST = HW'(H_SYNC + H_BP + FRAME_WIDTH - 1);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_SYNC);
  localparam logic [VW-1:0] V_ACT_BEG  = VW'(V_SYNC + V_BP);
  localparam logic [VW-1:0] V_ACT_END  = VW'(V_SYNC + V_BP + FRAME_HEIGHT);
  localparam logic [VW-1:0] V_ACT_LAST = VW'(V_SYNC + V_BP + FRAME_HEIGHT - 1);

  typedef enum logic [2:0] {
    ST_RESYNC    = 3'd0,
    ST_ARMED     = 3'd1,
    ST_WAIT_ROW  = 3'd2,
    ST_ROW_READY = 3'd3,
    ST_STREAM    = 3'd4,
    ST_WAIT_END  = 3'd5
  } state_t;

  state_t        r_state;
  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  logic          r_live;     // low only for the first clock after reset release
  logic          r_de, r_hs_n, r_vs_n, r_locked, r_underflow;
  logic [15:0]   r_rgb;

  logic w_de, w_start_next, w_row_last, w_last_row, w_top, w_wrap;
  logic w_is_frame, w_is_row, w_is_end, w_is_pixel, w_pop;
  logic [15:0] w_idle;

  assign w_de = (r_h >= H_ACT_BEG) && (r_h < H_ACT_END) &&
                (r_v >= V_ACT_BEG) && (r_v < V_ACT_END);
  // Entering STREAM one clock early puts the FSM in STREAM on the first active cycle.
  assign w_start_next = (r_h == H_PRE) && (r_v >= V_ACT_BEG) && (r_v < V_ACT_END);
  assign w_row_last   = (r_h == H_ACT_LAST);
  assign w_last_row   = (r_v == V_ACT_LAST);
  assign w_top        = (r_h == '0) && (r_v == '0);
  assign w_wrap       = (r_h == H_LAST) && (r_v == V_LAST);

  assign w_is_frame = (queue_data == 17'h10000);
  assign w_is_row   = (queue_data == 17'h10001);
  assign w_is_end   = (queue_data == 17'h1FFFF);
  assign w_is_pixel = ~queue_data[16];

`ifdef LCD_READER_BLUE_SCREEN_EN
  assign w_idle = r_locked ? 16'h0000 : 16'h001F;
`else
  assign w_idle = 16'h0000;
`endif

  always_comb begin
    w_pop = 1'b0;
    case (r_state)
      ST_RESYNC:   w_pop = ~queue_empty;
      ST_WAIT_ROW: w_pop = ~queue_empty & w_is_row & ~w_de;
      ST_STREAM:   w_pop = ~queue_empty & w_is_pixel & w_de;
      ST_WAIT_END: w_pop = ~queue_empty & w_is_end;
      default:     w_pop = 1'b0;
    endcase
  end

  assign queue_rd_en = r_live & w_pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_RESYNC;
      r_h         <= '0;
      r_v         <= '0;
      r_live      <= 1'b0;
      r_de        <= 1'b0;
      r_hs_n      <= 1'b1;
      r_vs_n      <= 1'b1;
      r_rgb       <= 16'h0000;
      r_locked    <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_live <= 1'b1;

      // Raster counters: never stall.
      if (r_h == H_LAST) begin
        r_h <= '0;
        r_v <= (r_v == V_LAST) ? '0 : r_v + VW'(1);
      end else begin
        r_h <= r_h + HW'(1);
      end

      // Syncs, DE and RGB all register from the same counter values.
      r_de   <= w_de;
      r_hs_n <= ~(r_h < H_SYNC_END);
      r_vs_n <= ~(r_v < V_SYNC_END);
      r_rgb  <= w_idle;

      case (r_state)
        ST_RESYNC: begin
          r_locked <= 1'b0;
          if (queue_rd_en && w_is_frame) r_state <= ST_ARMED;
        end
        ST_ARMED: begin
          if (w_top) r_state <= ST_WAIT_ROW;
        end
        ST_WAIT_ROW: begin
          if (w_de) begin
            r_underflow <= 1'b1;
            r_locked    <= 1'b0;
            r_state     <= ST_RESYNC;
          end else if (!queue_empty) begin
            if (w_is_row) begin
              if (w_start_next) begin
                r_locked <= 1'b1;
                r_state  <= ST_STREAM;
              end else begin
                r_state <= ST_ROW_READY;
              end
            end else begin
              r_locked <= 1'b0;
              r_state  <= ST_RESYNC;
            end
          end
        end
        ST_ROW_READY: begin
          if (w_start_next) begin
            r_locked <= 1'b1;
            r_state  <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          r_rgb <= 16'h0000;
          if (!w_de || queue_empty || !w_is_pixel) begin
            if (w_de && queue_empty) r_underflow <= 1'b1;
            r_locked <= 1'b0;
            r_state  <= ST_RESYNC;
          end else begin
            r_rgb <= queue_data[15:0];
            if (w_row_last) r_state <= w_last_row ? ST_WAIT_END : ST_WAIT_ROW;
          end
        end
        ST_WAIT_END: begin
          if (!queue_empty) begin
            r_locked <= 1'b0;
            r_state  <= ST_RESYNC;
          end else if (w_wrap) begin
            r_underflow <= 1'b1;
            r_locked    <= 1'b0;
            r_state     <= ST_RESYNC;
          end
        end
        default: begin
          r_locked <= 1'b0;
          r_state  <= ST_RESYNC;
        end
      endcase
    end
  end

  assign lcd_de      = r_de;
  assign lcd_hsync   = r_hs_n;
  assign lcd_vsync   = r_vs_n;
  assign lcd_r       = r_rgb[15:11];
  assign lcd_g       = r_rgb[10:5];
  assign lcd_b       = r_rgb[4:0];
  assign locked      = r_locked;
  assign underflow   = r_underflow;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_lcd_queue_reader.sv
// -----------------------------------------------------------------------------
// tb_lcd_queue_reader
//   Bench for lcd_queue_reader on a shrunk 16x12 raster. A queue models the
//   show-ahead FIFO; stimulus pushes stream words and, in the same order, the
//   expected {locked, RGB565} for every DE cycle. The monitor pops one expected
//   entry per displayed DE cycle and also checks raster timing.
// -----------------------------------------------------------------------------
module tb_lcd_queue_reader;

  localparam int TW = 16, TH = 12;
  localparam int HS = 2, HBP = 3, HFP = 2;
  localparam int VS = 1, VBP = 2, VFP = 1;
  localparam int HT = HS + HBP + TW + HFP;
  localparam int NPIX = TW * TH;

`ifdef LCD_READER_BLUE_SCREEN_EN
  localparam logic [15:0] IDLE = 16'h001F;
`else
  localparam logic [15:0] IDLE = 16'h0000;
`endif

  // clock / reset
  logic clk;
  logic reset_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [16:0] queue_data;
  logic        queue_empty;
  logic        queue_rd_en;
  logic        lcd_de, lcd_hsync, lcd_vsync;
  logic [4:0]  lcd_r;
  logic [5:0]  lcd_g;
  logic [4:0]  lcd_b;
  logic        locked, underflow;
  logic [2:0]  dbg_state;

  lcd_queue_reader #(
    .FRAME_WIDTH(TW), .FRAME_HEIGHT(TH),
    .H_SYNC(HS), .H_BP(HBP), .H_FP(HFP),
    .V_SYNC(VS), .V_BP(VBP), .V_FP(VFP)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .queue_data(queue_data), .queue_empty(queue_empty), .queue_rd_en(queue_rd_en),
    .lcd_de(lcd_de), .lcd_hsync(lcd_hsync), .lcd_vsync(lcd_vsync),
    .lcd_r(lcd_r), .lcd_g(lcd_g), .lcd_b(lcd_b),
    .locked(locked), .underflow(underflow), .o_dbg_state(dbg_state)
  );

  // scoreboard state
  logic [16:0] exp_q[$];
  logic [16:0] fifo_q[$];
  int chk_cnt = 0;
  int pass_cnt = 0;
  int de_seen = 0;
  int n_end = 0;

  logic [15:0] bar_c [10] = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFE0, 16'hF81F,
                              16'h07FF, 16'hFFFF, 16'h8410, 16'h4208, 16'h1234};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  function automatic logic [15:0] pix(input int tag, input int x, input int y);
    logic [15:0] c;
    c = bar_c[(x * 10) / TW];
    return c ^ {tag[3:0], 8'h00, y[3:0]};
  endfunction

  // driver tasks
  task automatic push_stream(input int tag, input int n_px, input bit with_end);
    fifo_q.push_back(17'h10000);
    for (int i = 0; i < n_px; i++) begin
      if (i % TW == 0) fifo_q.push_back(17'h10001);
      fifo_q.push_back({1'b0, pix(tag, i % TW, i / TW)});
    end
    if (with_end) fifo_q.push_back(17'h1FFFF);
  endtask

  task automatic exp_frame(input int tag, input int n_shown, input bit starve);
    for (int i = 0; i < NPIX; i++) begin
      if (i < n_shown) exp_q.push_back({1'b1, pix(tag, i % TW, i / TW)});
      else if (starve && i == n_shown) exp_q.push_back(17'h00000);
      else exp_q.push_back({1'b0, IDLE});
    end
  endtask

  task automatic wait_de(input string name, input int n, input int budget);
    int k;
    k = 0;
    while (de_seen < n && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    check(name, 32'(de_seen >= n), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_de"}, 32'(lcd_de), 32'd0);
    check({tag, "_hsync"}, 32'(lcd_hsync), 32'd1);
    check({tag, "_vsync"}, 32'(lcd_vsync), 32'd1);
    check({tag, "_rgb"}, 32'({lcd_r, lcd_g, lcd_b}), 32'd0);
    check({tag, "_locked"}, 32'(locked), 32'd0);
    check({tag, "_underflow"}, 32'(underflow), 32'd0);
    check({tag, "_rd_en"}, 32'(queue_rd_en), 32'd0);
  endtask

  // show-ahead FIFO model: pop decision taken mid-cycle, applied after the edge
  logic do_pop;
  initial begin
    queue_empty = 1'b1;
    queue_data  = 17'h0;
  end
  always begin
    @(negedge clk);
    do_pop = queue_rd_en && !queue_empty;
    @(posedge clk); #1;
    if (do_pop && fifo_q.size() > 0) begin
      if (fifo_q.pop_front() == 17'h1FFFF) n_end++;
    end
    queue_empty = (fifo_q.size() == 0);
    queue_data  = queue_empty ? 17'h0 : fifo_q[0];
  end

  // monitor
  int hs_cnt = 0, de_lines = 0;
  bit have_hs = 0, have_vs = 0, prev_hs = 1, prev_vs = 1, prev_de = 0;
  logic [16:0] e;
  always @(negedge clk) begin
    if (!reset_n) begin
      have_hs = 0; have_vs = 0; prev_hs = 1; prev_vs = 1; prev_de = 0;
    end else begin
      hs_cnt++;
      if (prev_hs && !lcd_hsync) begin
        if (have_hs) check("hsync_period", 32'(hs_cnt), 32'(HT));
        have_hs = 1;
        hs_cnt = 0;
      end
      if (lcd_de && !prev_de) begin
        if (have_hs) check("de_offset", 32'(hs_cnt), 32'(HS + HBP));
        de_lines++;
      end
      if (prev_vs && !lcd_vsync) begin
        if (have_vs) check("de_lines", 32'(de_lines), 32'(TH));
        have_vs = 1;
        de_lines = 0;
      end
      if (lcd_de) begin
        de_seen++;
        if (exp_q.size() == 0) begin
          chk_cnt++;
          $display("FAIL pixel#%0d: got %0h, want no DE", de_seen, {locked, lcd_r, lcd_g, lcd_b});
        end else begin
          e = exp_q.pop_front();
          check($sformatf("pixel#%0d", de_seen), 32'({locked, lcd_r, lcd_g, lcd_b}), 32'(e));
        end
      end
      prev_hs = lcd_hsync;
      prev_vs = lcd_vsync;
      prev_de = lcd_de;
    end
  end

  // stimulus
  initial begin
    reset_n = 1'b0;
    fifo_q.push_back(17'h00ABC);
    fifo_q.push_back(17'h01234);
    fifo_q.push_back(17'h0F00F);
    fifo_q.push_back(17'h05555);
    fifo_q.push_back(17'h0AAAA);
    push_stream(1, NPIX, 1'b1);          // A
    push_stream(2, NPIX, 1'b1);          // B
    push_stream(3, 3 * TW + 10, 1'b0);   // C: starves at row 3 pixel 10
    exp_frame(0, 0, 1'b0);               // first frame after reset: idle
    exp_frame(1, NPIX, 1'b0);
    exp_frame(2, NPIX, 1'b0);
    exp_frame(3, 3 * TW + 10, 1'b1);

    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("reset");
    reset_n = 1'b1;

    wait_de("wait_frames_ab", 3 * NPIX, 1500);
    repeat (5) @(negedge clk);
    check("underflow_clean", 32'(underflow), 32'd0);
    check("end_words_ab", 32'(n_end), 32'd2);
    check("locked_between_frames", 32'(locked), 32'd0);

    begin : wait_starve
      int k;
      k = 0;
      while (!underflow && k < 1000) begin
        @(negedge clk); #1;
        k++;
      end
    end
    check("starve_underflow", 32'(underflow), 32'd1);
    check("starve_locked", 32'(locked), 32'd0);

    push_stream(4, NPIX, 1'b1);          // D: relock after starvation
    push_stream(5, 10 * TW, 1'b0);       // E: row 10 start replaced by F's frame start
    push_stream(6, NPIX, 1'b1);          // F
    push_stream(7, NPIX, 1'b1);          // G: interrupted by reset on row 5
    exp_frame(4, NPIX, 1'b0);
    exp_frame(5, 10 * TW, 1'b0);
    exp_frame(6, NPIX, 1'b0);
    exp_frame(7, NPIX, 1'b0);

    wait_de("wait_mid_line5", 7 * NPIX + 5 * TW + 8, 4000);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midline_reset");
    exp_q.delete();
    push_stream(8, NPIX, 1'b1);          // H
    exp_frame(0, 0, 1'b0);
    exp_frame(8, NPIX, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b1;

    wait_de("wait_frame_h", de_seen + 2 * NPIX, 1500);
    repeat (10) @(negedge clk);
    check("underflow_after_reset", 32'(underflow), 32'd0);
    check("end_words_total", 32'(n_end), 32'd6);
    check("exp_drained", 32'(exp_q.size()), 32'd0);
    check("fifo_drained", 32'(fifo_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
